// File: rtl/alu_bitserial_seq_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
// Holds the sequencer state encoding and the alu_1bit op-select codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic [1:0] S_OP_AND = 2'b00;
  localparam logic [1:0] S_OP_OR  = 2'b01;
  localparam logic [1:0] S_OP_ADD = 2'b10;
  localparam logic [1:0] S_OP_XOR = 2'b11;

endpackage

// File: rtl/alu_bitserial_seq_if.sv
// Operand/result bundle between the sequencer and its neighbours.
// A transfer on either side happens on a rising clk edge where valid && ready are both high;
// valid must not depend on ready, and the payload is only meaningful while valid is high.
interface alu_bitserial_seq_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [1:0]       s_op_in;
    logic             cin_in;
    logic             b_inv_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout_out;
    logic             zero;

    modport slave (
        input  in_valid, a_in, b_in, s_op_in, cin_in, b_inv_in, out_ready,
        output in_ready, out_valid, result, cout_out, zero
    );

    modport master (
        output in_valid, a_in, b_in, s_op_in, cin_in, b_inv_in, out_ready,
        input  in_ready, out_valid, result, cout_out, zero
    );

endinterface

// File: rtl/alu_bitserial_seq_alu_1bit.sv
// One-bit ALU slice driven serially by the sequencer.
// Logic ops produce no carry, so cout is 0 for everything except add.
module alu_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] s_op,
    output logic       z,
    output logic       cout
);

    always_comb begin
        z    = 1'b0;
        cout = 1'b0;
        case (s_op)
            S_OP_AND: z = a & b;
            S_OP_OR:  z = a | b;
            S_OP_ADD: begin
                z    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            default:  z = a ^ b;
        endcase
    end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer: loads an operand pair, feeds alu_1bit LSB first for WIDTH cycles,
// then holds the assembled result and final carry until downstream takes them.
module alu_bitserial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_bitserial_seq_if.slave  bus,
    output seq_state_t          dbg_state
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [1:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             z;
    logic             cout;
    logic             load;
    logic             step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result fills from the top: bit 0 lands in res[0] after exactly WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            op_q  <= S_OP_ADD;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sr  <= bus.a_in;
            b_sr  <= bus.b_inv_in ? ~bus.b_in : bus.b_in;
            op_q  <= bus.s_op_in;
            carry <= bus.cin_in;
            cnt   <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            res   <= {z, res[WIDTH-1:1]};
            carry <= cout;
            cnt   <= cnt + CW'(1);
        end
    end

    alu_1bit u_alu (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s_op (op_q),
        .z    (z),
        .cout (cout)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res;
    assign bus.cout_out  = carry;
    assign bus.zero      = (res == '0);
    assign dbg_state     = state;

endmodule
